// File: rtl/lbuf_pkg.sv
// lbuf_pkg: shared types and widths for the line-buffer arbiter.
//   pixel_t       15-bit BGR555 pixel, {B,G,R}
//   lbuf_entry_t  queued write: {bank, col[8:0], pixel}
//   LBUF_ADDR_W   line RAM address width, {bank, col}
package lbuf_pkg;

    localparam int LBUF_ADDR_W = 10;
    localparam int LBUF_COL_W  = 9;
    localparam int LBUF_LVL_W  = 5;   // holds 0..16 entries

    typedef logic [14:0] pixel_t;

    typedef struct packed {
        logic                  bank;
        logic [LBUF_COL_W-1:0] col;
        pixel_t                pixel;
    } lbuf_entry_t;

    function automatic logic [LBUF_ADDR_W-1:0] entry_addr(input lbuf_entry_t e);
        return {e.bank, e.col};
    endfunction

endpackage

// File: rtl/line_buf_arbiter_if.sv
// line_buf_arbiter_if: bus to the single-port line RAM (1-cycle synchronous read).
//   ram_addr  {bank, col}
//   ram_we    write strobe
//   ram_wdata write data
//   ram_rdata read data, valid the cycle after the address was presented
// Modports: master = arbiter side, slave = RAM side.
interface line_buf_arbiter_if;
    import lbuf_pkg::*;

    logic [LBUF_ADDR_W-1:0] ram_addr;
    logic                   ram_we;
    pixel_t                 ram_wdata;
    pixel_t                 ram_rdata;

    modport master (output ram_addr, output ram_we, output ram_wdata, input ram_rdata);
    modport slave  (input ram_addr, input ram_we, input ram_wdata, output ram_rdata);
endinterface

// File: rtl/lbuf_fifo.sv
// lbuf_fifo: synchronous write queue with show-ahead head.
//   clk, reset  clock, synchronous active-high reset
//   flush_i     empty the queue; a same-cycle push lands in the emptied queue
//   push_i      enqueue din_i (caller guarantees room, or a same-cycle pop)
//   pop_i       drop the head (caller guarantees non-empty)
//   head_o      current head entry, valid while !empty_o
//   empty_o, full_o, level_o   occupancy, level registered (0..DEPTH)
module lbuf_fifo
    import lbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  lbuf_entry_t           din_i,
    input  logic                  pop_i,
    output lbuf_entry_t           head_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [LBUF_LVL_W-1:0] level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LBUF_LVL_W-1:0] DEPTH_LVL = LBUF_LVL_W'(DEPTH);

    lbuf_entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LBUF_LVL_W-1:0] level_q;
    logic [PTR_W-1:0]      wr_slot;

    // A flush rewinds both pointers, so a coincident push goes to slot 0.
    assign wr_slot = flush_i ? '0 : wr_ptr_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= push_i ? PTR_W'(1) : '0;
            level_q  <= LBUF_LVL_W'(push_i);
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LBUF_LVL_W'(push_i) - LBUF_LVL_W'(pop_i);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and level define
    // which slots are meaningful, and an unreset array maps to plain RAM/regs.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_slot] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == DEPTH_LVL);
    assign level_o = level_q;
endmodule

// File: rtl/line_buf_arbiter.sv
// line_buf_arbiter: double-banked line buffer arbiter between a PPU pixel
// writer and scan-out reads on one single-port line RAM.
//   clk, reset                  clock, synchronous active-high reset
//   wr_valid, wr_pixel          PPU pixel strobe and BGR555 data
//   wr_line_start, frame_start  line toggles the write bank; frame flushes all
//   rd_en, rd_col               scan-out read of the bank not being written
//   rd_pixel, rd_valid          read data one cycle after rd_en (0 otherwise)
//   ram                         line RAM bus (master side)
//   wr_overflow                 sticky pixel-drop flag, cleared by frame_start
//   fifo_level                  write-queue occupancy
//   drop_count                  dropped-pixel count (LBUF_STATS_EN), else 0
// Build option: define LBUF_STATS_EN to include the saturating drop counter.
module line_buf_arbiter
    import lbuf_pkg::*;
#(
    parameter int LINE_W     = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  pixel_t                wr_pixel,
    input  logic                  wr_line_start,
    input  logic                  frame_start,
    input  logic                  rd_en,
    input  logic [LBUF_COL_W-1:0] rd_col,
    output pixel_t                rd_pixel,
    output logic                  rd_valid,
    line_buf_arbiter_if.master    ram,
    output logic                  wr_overflow,
    output logic [LBUF_LVL_W-1:0] fifo_level,
    output logic [15:0]           drop_count
);
    // The column counter is one bit wider than a RAM column so it can rest
    // at LINE_W (up to 512) once a line is full.
    localparam int CNT_W = LBUF_COL_W + 1;
    localparam logic [CNT_W-1:0] COL_LIMIT = CNT_W'(LINE_W);

    logic             wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0] wr_col_q, wr_col_d;
    logic             wr_overflow_q, wr_overflow_d;
    logic             rd_valid_q;

    logic        flush, push, pop;
    lbuf_entry_t push_entry, head;
    logic        fifo_empty, fifo_full;

    lbuf_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    // Write side: frame_start, then wr_line_start, then the pixel itself.
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        wr_bank_d     = wr_bank_q;
        wr_col_d      = wr_col_q;
        wr_overflow_d = wr_overflow_q;
        flush         = 1'b0;
        push          = 1'b0;
        push_entry    = '0;

        if (frame_start) begin
            wr_bank_d     = 1'b0;
            wr_col_d      = '0;
            flush         = 1'b1;
            wr_overflow_d = 1'b0;
        end
        if (wr_line_start) begin
            wr_bank_d = ~wr_bank_d;
            wr_col_d  = '0;
        end

        // The RAM slot goes to a write only when no read wants it; nothing
        // queued before a frame_start may reach the RAM.
        pop = !rd_en && !fifo_empty && !frame_start;

        if (wr_valid) begin
            // A full queue still accepts when the head leaves this cycle.
            if (wr_col_d < COL_LIMIT && (!fifo_full || pop || flush)) begin
                push       = 1'b1;
                push_entry = '{bank: wr_bank_d, col: wr_col_d[LBUF_COL_W-1:0], pixel: wr_pixel};
                wr_col_d   = wr_col_d + 1'b1;
            end else begin
                wr_overflow_d = 1'b1;
            end
        end
    end

    // RAM slot schedule; held idle (all zero) while reset is asserted.
    always_comb begin
        ram.ram_addr  = '0;
        ram.ram_we    = 1'b0;
        ram.ram_wdata = '0;
        if (!reset) begin
            if (rd_en) begin
                ram.ram_addr = {~wr_bank_q, rd_col};
            end else if (pop) begin
                ram.ram_addr  = entry_addr(head);
                ram.ram_we    = 1'b1;
                ram.ram_wdata = head.pixel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q     <= 1'b0;
            wr_col_q      <= '0;
            wr_overflow_q <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            wr_col_q      <= wr_col_d;
            wr_overflow_q <= wr_overflow_d;
            rd_valid_q    <= rd_en;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_pixel    = rd_valid_q ? ram.ram_rdata : '0;
    assign wr_overflow = wr_overflow_q;

`ifdef LBUF_STATS_EN
    logic        drop;
    logic [15:0] drop_cnt_q;

    assign drop = wr_valid && !push;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif
endmodule

// File: tb/tb_line_buf_arbiter.sv
// tb_line_buf_arbiter: directed self-checking bench for line_buf_arbiter with
// a behavioural 1-cycle-read line RAM. Inputs change 1 time unit after the
// rising edge; RAM-side outputs are compared on the falling edge, registered
// outputs just after the rising edge.
module tb_line_buf_arbiter;
    import lbuf_pkg::*;

    localparam int LINE_W     = 256;
    localparam int FIFO_DEPTH = 4;
`ifdef LBUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  wr_valid;
    pixel_t                wr_pixel;
    logic                  wr_line_start;
    logic                  frame_start;
    logic                  rd_en;
    logic [LBUF_COL_W-1:0] rd_col;
    pixel_t                rd_pixel;
    logic                  rd_valid;
    logic                  wr_overflow;
    logic [LBUF_LVL_W-1:0] fifo_level;
    logic [15:0]           drop_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    line_buf_arbiter_if ram_bus ();

    line_buf_arbiter #(.LINE_W(LINE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_pixel      (wr_pixel),
        .wr_line_start (wr_line_start),
        .frame_start   (frame_start),
        .rd_en         (rd_en),
        .rd_col        (rd_col),
        .rd_pixel      (rd_pixel),
        .rd_valid      (rd_valid),
        .ram           (ram_bus),
        .wr_overflow   (wr_overflow),
        .fifo_level    (fifo_level),
        .drop_count    (drop_count)
    );

    // Background pattern so reads of never-written cells are recognisable.
    function automatic pixel_t pat(input int a);
        int t;
        t = a * 37 + 5;
        return t[14:0];
    endfunction

    // Line RAM model, filled with the pattern on the first edge (under reset).
    pixel_t mem [1024];
    bit     filled = 1'b0;
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
            filled <= 1'b1;
        end else if (ram_bus.ram_we) begin
            mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
        end
        ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
    end

    // Log of every RAM write as {addr, data}.
    logic [LBUF_ADDR_W+14:0] wlog [$];
    always @(negedge clk) begin
        if (ram_bus.ram_we === 1'b1) wlog.push_back({ram_bus.ram_addr, ram_bus.ram_wdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_drops(input int n);
        return STATS ? n[15:0] : 16'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid      = 1'b0;
        wr_pixel      = '0;
        wr_line_start = 1'b0;
        frame_start   = 1'b0;
        rd_en         = 1'b0;
        rd_col        = '0;
    endtask

    typedef struct {
        logic                   wv;
        pixel_t                 px;
        logic                   ls;
        logic                   fs;
        logic                   rd;
        logic [LBUF_COL_W-1:0]  col;
        logic                   we;
        logic [LBUF_ADDR_W-1:0] addr;
        pixel_t                 wd;
        logic [LBUF_LVL_W-1:0]  lvl;
        logic                   rdv;
        pixel_t                 rpx;
        logic                   ovf;
        logic [15:0]            drops;
    } vec_t;

    function automatic vec_t mkv(input int wv, input int px, input int ls, input int fs,
                                 input int rd, input int col, input int we, input int addr,
                                 input int wd, input int lvl, input int rdv, input int rpx,
                                 input int ovf, input int drops);
        vec_t v;
        v.wv = wv[0];   v.px = px[14:0];  v.ls = ls[0];      v.fs = fs[0];
        v.rd = rd[0];   v.col = col[8:0]; v.we = we[0];      v.addr = addr[9:0];
        v.wd = wd[14:0]; v.lvl = lvl[4:0]; v.rdv = rdv[0];   v.rpx = rpx[14:0];
        v.ovf = ovf[0]; v.drops = drops[15:0];
        return v;
    endfunction

    vec_t vecs [24];
    int   base;

    initial begin
        //            wv  px      ls fs rd col     we addr    wd       lvl rdv rpx         ovf drops
        vecs[0]  = mkv(1, 'h001,  0, 0, 0, 0,      0, 0,      0,       1,  0,  0,          0,  0);
        vecs[1]  = mkv(1, 'h002,  0, 0, 0, 0,      1, 'h000,  'h001,   1,  0,  0,          0,  0);
        vecs[2]  = mkv(1, 'h003,  0, 0, 0, 0,      1, 'h001,  'h002,   1,  0,  0,          0,  0);
        vecs[3]  = mkv(1, 'h004,  0, 0, 0, 0,      1, 'h002,  'h003,   1,  0,  0,          0,  0);
        vecs[4]  = mkv(0, 0,      0, 0, 0, 0,      1, 'h003,  'h004,   0,  0,  0,          0,  0);
        vecs[5]  = mkv(0, 0,      0, 0, 0, 0,      0, 0,      0,       0,  0,  0,          0,  0);
        vecs[6]  = mkv(1, 'h010,  0, 0, 1, 5,      0, 'h205,  0,       1,  1,  pat('h205), 0,  0);
        vecs[7]  = mkv(1, 'h011,  0, 0, 1, 5,      0, 'h205,  0,       2,  1,  pat('h205), 0,  0);
        vecs[8]  = mkv(1, 'h012,  0, 0, 1, 5,      0, 'h205,  0,       3,  1,  pat('h205), 0,  0);
        vecs[9]  = mkv(1, 'h013,  0, 0, 1, 5,      0, 'h205,  0,       4,  1,  pat('h205), 0,  0);
        vecs[10] = mkv(1, 'h014,  0, 0, 1, 5,      0, 'h205,  0,       4,  1,  pat('h205), 1,  1);
        vecs[11] = mkv(0, 0,      0, 0, 1, 5,      0, 'h205,  0,       4,  1,  pat('h205), 1,  1);
        vecs[12] = mkv(1, 'h015,  0, 0, 0, 0,      1, 'h004,  'h010,   4,  0,  0,          1,  1);
        vecs[13] = mkv(0, 0,      0, 0, 0, 0,      1, 'h005,  'h011,   3,  0,  0,          1,  1);
        vecs[14] = mkv(0, 0,      0, 0, 0, 0,      1, 'h006,  'h012,   2,  0,  0,          1,  1);
        vecs[15] = mkv(0, 0,      0, 0, 0, 0,      1, 'h007,  'h013,   1,  0,  0,          1,  1);
        vecs[16] = mkv(0, 0,      0, 0, 0, 0,      1, 'h008,  'h015,   0,  0,  0,          1,  1);
        vecs[17] = mkv(0, 0,      1, 0, 0, 0,      0, 0,      0,       0,  0,  0,          1,  1);
        vecs[18] = mkv(1, 'h7FFF, 0, 0, 0, 0,      0, 0,      0,       1,  0,  0,          1,  1);
        vecs[19] = mkv(0, 0,      0, 0, 0, 0,      1, 'h200,  'h7FFF,  0,  0,  0,          1,  1);
        vecs[20] = mkv(0, 0,      0, 0, 1, 0,      0, 'h000,  0,       0,  1,  'h001,      1,  1);
        vecs[21] = mkv(0, 0,      0, 0, 0, 0,      0, 0,      0,       0,  0,  0,          1,  1);
        vecs[22] = mkv(0, 0,      0, 0, 1, 'h12C,  0, 'h12C,  0,       0,  1,  pat('h12C), 1,  1);
        vecs[23] = mkv(0, 0,      0, 0, 0, 0,      0, 0,      0,       0,  0,  0,          1,  1);

        // Reset state
        idle_inputs();
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst.ram_we",    32'(ram_bus.ram_we),    0);
        check("rst.ram_addr",  32'(ram_bus.ram_addr),  0);
        check("rst.ram_wdata", 32'(ram_bus.ram_wdata), 0);
        step();
        check("rst.rd_valid",    32'(rd_valid),    0);
        check("rst.rd_pixel",    32'(rd_pixel),    0);
        check("rst.fifo_level",  32'(fifo_level),  0);
        check("rst.wr_overflow", 32'(wr_overflow), 0);
        check("rst.drop_count",  32'(drop_count),  0);
        reset = 1'b0;

        // Idle writes, read priority with a full queue, banking, far-column read
        for (int i = 0; i < 24; i++) begin
            wr_valid      = vecs[i].wv;
            wr_pixel      = vecs[i].px;
            wr_line_start = vecs[i].ls;
            frame_start   = vecs[i].fs;
            rd_en         = vecs[i].rd;
            rd_col        = vecs[i].col;
            @(negedge clk);
            check($sformatf("v%0d.ram_we", i), 32'(ram_bus.ram_we), 32'(vecs[i].we));
            if (vecs[i].we || vecs[i].rd)
                check($sformatf("v%0d.ram_addr", i), 32'(ram_bus.ram_addr), 32'(vecs[i].addr));
            if (vecs[i].we)
                check($sformatf("v%0d.ram_wdata", i), 32'(ram_bus.ram_wdata), 32'(vecs[i].wd));
            step();
            check($sformatf("v%0d.fifo_level", i),  32'(fifo_level),  32'(vecs[i].lvl));
            check($sformatf("v%0d.rd_valid", i),    32'(rd_valid),    32'(vecs[i].rdv));
            check($sformatf("v%0d.rd_pixel", i),    32'(rd_pixel),    32'(vecs[i].rpx));
            check($sformatf("v%0d.wr_overflow", i), 32'(wr_overflow), 32'(vecs[i].ovf));
            check($sformatf("v%0d.drop_count", i),  32'(drop_count),  32'(exp_drops(int'(vecs[i].drops))));
        end
        idle_inputs();

        // frame_start clears the sticky flag but not the drop counter
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("fs.wr_overflow", 32'(wr_overflow), 0);
        check("fs.drop_count",  32'(drop_count),  32'(exp_drops(1)));

        // Line overflow: LINE_W+2 pixels, last two dropped
        base = wlog.size();
        for (int i = 0; i < LINE_W + 2; i++) begin
            wr_valid = 1'b1;
            wr_pixel = 15'(i + 1);
            step();
        end
        idle_inputs();
        repeat (3) step();
        check("lov.writes", 32'(wlog.size() - base), 32'(LINE_W));
        if (wlog.size() - base == LINE_W) begin
            check("lov.first_addr", 32'(wlog[base][24:15]), 0);
            check("lov.last_addr",  32'(wlog[base+LINE_W-1][24:15]), 32'(LINE_W - 1));
            check("lov.last_data",  32'(wlog[base+LINE_W-1][14:0]),  32'(LINE_W));
        end
        check("lov.wr_overflow", 32'(wr_overflow), 1);
        check("lov.drop_count",  32'(drop_count),  32'(exp_drops(3)));
        check("lov.fifo_level",  32'(fifo_level),  0);

        // Flush: three queued entries discarded by frame_start
        wr_line_start = 1'b1;
        step();
        wr_line_start = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_pixel = 15'('h21 + i);
            step();
        end
        wr_valid = 1'b0;
        check("fl.level_before", 32'(fifo_level), 3);
        base = wlog.size();
        frame_start = 1'b1;
        step();
        idle_inputs();
        check("fl.fifo_level",  32'(fifo_level),  0);
        check("fl.wr_overflow", 32'(wr_overflow), 0);
        repeat (3) step();
        check("fl.no_stale", 32'(wlog.size() - base), 0);
        wr_valid = 1'b1;
        wr_pixel = 15'h0AB;
        step();
        idle_inputs();
        repeat (2) step();
        check("fl.new_writes", 32'(wlog.size() - base), 1);
        if (wlog.size() - base == 1) begin
            check("fl.bank0_addr", 32'(wlog[base][24:15]), 0);
            check("fl.bank0_data", 32'(wlog[base][14:0]),  32'h0AB);
        end

        // Reset in the cycle after rd_en, with writes queued
        rd_en = 1'b1;
        rd_col = 9'd3;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_pixel = 15'('h31 + i);
            step();
        end
        idle_inputs();
        base = wlog.size();
        reset = 1'b1;
        @(negedge clk);
        check("mrst.ram_we",    32'(ram_bus.ram_we),    0);
        check("mrst.ram_addr",  32'(ram_bus.ram_addr),  0);
        check("mrst.ram_wdata", 32'(ram_bus.ram_wdata), 0);
        step();
        check("mrst.rd_valid",    32'(rd_valid),    0);
        check("mrst.rd_pixel",    32'(rd_pixel),    0);
        check("mrst.fifo_level",  32'(fifo_level),  0);
        check("mrst.wr_overflow", 32'(wr_overflow), 0);
        check("mrst.drop_count",  32'(drop_count),  0);
        reset = 1'b0;
        repeat (3) step();
        check("mrst.discarded", 32'(wlog.size() - base), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
